crypt_round_sequencer: RTL and testbench

//  Round controller for the S-LUT / key-schedule datapath. Accepts one 32-bit block over a valid/ready

---
 rtl/crypt_seq_pkg.sv | 19 +
 rtl/crypt_key_idx_counter.sv | 44 ++++
 rtl/crypt_round_sequencer.sv | 120 ++++++++++++
 tb/tb_crypt_round_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crypt_seq_pkg.sv
// Shared types and constants for the round sequencer and its key-index counter.
package crypt_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // A single round still needs a 1-bit select.
  function automatic int key_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crypt_key_idx_counter.sv
// Round counter: loads at block accept, steps once per completed round, and
// maps the round number to a key index in ascending or descending order.
module crypt_key_idx_counter
  import crypt_seq_pkg::*;
#(
  parameter int NUM_ROUNDS = 3,
  parameter int KW         = key_idx_w(NUM_ROUNDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic          mode,
  input  logic          step,
  output logic [KW-1:0] key_idx,
  output logic          last,
  output logic          bad
);

  localparam logic [KW-1:0] LAST_RND = KW'(NUM_ROUNDS - 1);

  logic [KW-1:0] rnd;
  logic          dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd <= '0;
      dir <= MODE_ENC;
    end else if (en) begin
      if (load) begin
        rnd <= '0;
        dir <= mode;
      end else if (step) begin
        rnd <= rnd + 1'b1;
      end
    end
  end

  assign key_idx = (dir == MODE_DEC) ? (LAST_RND - rnd) : rnd;
  assign last    = (rnd == LAST_RND);
  // Encodings past the last round cannot be reached; flag them so the FSM can bail out.
  assign bad     = (rnd > LAST_RND);

endmodule

// File: rtl/crypt_round_sequencer.sv
// Round controller: accepts one block, runs it through NUM_ROUNDS datapath
// passes (issue, wait LUT_LAT, capture) and returns the result.
module crypt_round_sequencer
  import crypt_seq_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_ROUNDS = 3,
  parameter int LUT_LAT    = 1,
  localparam int KW        = key_idx_w(NUM_ROUNDS),
  localparam int WW        = (LUT_LAT > 1) ? $clog2(LUT_LAT) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              GLOBAL_EN,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              MODE,
  output logic              LUT_EN,
  output logic [DATA_W-1:0] LUT_DIN,
  output logic [KW-1:0]     KEY_IDX,
  input  logic [DATA_W-1:0] LUT_DOUT,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              BUSY
);

  localparam logic [WW-1:0] WAIT_LAST = WW'(LUT_LAT - 1);

  seq_state_t        fsm;
  logic [DATA_W-1:0] state_reg;
  logic [DATA_W-1:0] out_data_q;
  logic [WW-1:0]     wcnt;
  logic              lut_en_q;
  logic              out_valid_q;

  logic cnt_load, cnt_step, cnt_last, cnt_bad, wait_end;

  always_comb begin
    wait_end = (fsm == S_WAIT) && (wcnt == WAIT_LAST);
    cnt_load = (fsm == S_IDLE) && IN_VALID;
    cnt_step = wait_end && !cnt_last;
  end

  crypt_key_idx_counter #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .KW         (KW)
  ) u_key_cnt (
    .clk     (CLK),
    .rst     (RST),
    .en      (GLOBAL_EN),
    .load    (cnt_load),
    .mode    (MODE),
    .step    (cnt_step),
    .key_idx (KEY_IDX),
    .last    (cnt_last),
    .bad     (cnt_bad)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsm         <= S_IDLE;
      state_reg   <= '0;
      out_data_q  <= '0;
      wcnt        <= '0;
      lut_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (GLOBAL_EN) begin
      case (fsm)
        S_IDLE: begin
          if (IN_VALID) begin
            state_reg <= IN_DATA;
            lut_en_q  <= 1'b1;
            fsm       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          lut_en_q <= 1'b0;
          wcnt     <= '0;
          fsm      <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == WAIT_LAST) begin
            state_reg <= LUT_DOUT;
            wcnt      <= '0;
            if (cnt_bad) begin
              fsm <= S_IDLE;
            end else if (cnt_last) begin
              out_data_q  <= LUT_DOUT;
              out_valid_q <= 1'b1;
              fsm         <= S_DONE;
            end else begin
              lut_en_q <= 1'b1;
              fsm      <= S_ISSUE;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_DONE: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            fsm         <= S_IDLE;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  // LUT_DIN holds the ISSUE value through WAIT because state_reg only moves at capture.
  assign IN_READY  = (fsm == S_IDLE) && GLOBAL_EN && !RST;
  assign LUT_EN    = lut_en_q && GLOBAL_EN;
  assign LUT_DIN   = state_reg;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign BUSY      = (fsm != S_IDLE);

endmodule

// File: tb/tb_crypt_round_sequencer.sv
// Directed bench for crypt_round_sequencer with a 1-cycle adder datapath stub
// and a cycle-count model of the block's externally visible behaviour.
module tb_crypt_round_sequencer;

  localparam int DW    = 32;
  localparam int NR    = 3;
  localparam int LAT   = 1;
  localparam int PER   = 1 + LAT;
  localparam int LATCY = NR * PER;

  logic          CLK, RST, GLOBAL_EN, IN_VALID, IN_READY, MODE, LUT_EN;
  logic          OUT_VALID, OUT_READY, BUSY;
  logic [DW-1:0] IN_DATA, LUT_DIN, LUT_DOUT, OUT_DATA;
  logic [1:0]    KEY_IDX;

  int checks = 0;
  int errors = 0;

  crypt_round_sequencer #(.DATA_W(DW), .NUM_ROUNDS(NR), .LUT_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST), .GLOBAL_EN(GLOBAL_EN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .MODE(MODE),
    .LUT_EN(LUT_EN), .LUT_DIN(LUT_DIN), .KEY_IDX(KEY_IDX), .LUT_DOUT(LUT_DOUT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Datapath stub: result = din + (key+1), one cycle after the issue strobe.
  initial LUT_DOUT = '0;
  always @(posedge CLK)
    if (GLOBAL_EN && LUT_EN) LUT_DOUT <= LUT_DIN + 32'(KEY_IDX) + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int key_at(input int r, input logic m);
    return m ? (NR - 1 - r) : r;
  endfunction

  function automatic logic [31:0] partial(input logic [31:0] d, input logic m, input int r);
    logic [31:0] s;
    s = d;
    for (int i = 0; i < r; i++) s += 32'(key_at(i, m) + 1);
    return s;
  endfunction

  // Model: a block is in flight for LATCY enabled cycles, then waits for the output handshake.
  bit          m_active;
  int          m_cnt;
  logic [31:0] m_data;
  logic        m_mode;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_active = 1'b0;
      m_cnt    = 0;
    end else if (GLOBAL_EN) begin
      if (m_active) begin
        if (m_cnt >= LATCY) begin
          if (OUT_READY) m_active = 1'b0;
        end else begin
          m_cnt++;
        end
      end else if (IN_VALID) begin
        m_active = 1'b1;
        m_cnt    = 0;
        m_data   = IN_DATA;
        m_mode   = MODE;
      end
    end
  end

  logic [1:0] kseq[$];

  always @(negedge CLK) begin
    int r;
    if (!RST) begin
      chk("busy", 32'(BUSY), 32'(m_active));
      chk("in_ready", 32'(IN_READY), 32'(!m_active && GLOBAL_EN));
      chk("out_valid", 32'(OUT_VALID), 32'(m_active && m_cnt >= LATCY));
      chk("lut_en", 32'(LUT_EN),
          32'(m_active && m_cnt < LATCY && (m_cnt % PER == 0) && GLOBAL_EN));
      if (m_active && m_cnt < LATCY) begin
        r = m_cnt / PER;
        chk("key_idx", 32'(KEY_IDX), 32'(key_at(r, m_mode)));
        chk("lut_din", LUT_DIN, partial(m_data, m_mode, r));
      end
      if (m_active && m_cnt >= LATCY)
        chk("out_data", OUT_DATA, partial(m_data, m_mode, NR));
      if (LUT_EN) kseq.push_back(KEY_IDX);
    end
  end

  task automatic offer(input logic [31:0] d, input logic m);
    int g;
    g = 0;
    while (!IN_READY && g < 100) begin
      @(posedge CLK); #1; g++;
    end
    chk("offer_ready", 32'(IN_READY), 32'd1);
    kseq.delete();
    IN_VALID = 1'b1;
    IN_DATA  = d;
    MODE     = m;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic wait_out(input string name, input int drop_at, input int drop_len,
                          input int exp_lat, input logic [31:0] exp_out);
    int n;
    n = 0;
    while (n < 200) begin
      @(posedge CLK); #1; n++;
      if (n == drop_at) GLOBAL_EN = 1'b0;
      if (n == drop_at + drop_len) GLOBAL_EN = 1'b1;
      if (OUT_VALID) break;
    end
    chk({name, "_latency"}, 32'(n), 32'(exp_lat));
    chk({name, "_data"}, OUT_DATA, exp_out);
  endtask

  task automatic chk_keys(input string name, input logic [1:0] k0, input logic [1:0] k1,
                          input logic [1:0] k2);
    chk({name, "_nkeys"}, 32'(kseq.size()), 32'd3);
    if (kseq.size() == 3) begin
      chk({name, "_k0"}, 32'(kseq[0]), 32'(k0));
      chk({name, "_k1"}, 32'(kseq[1]), 32'(k1));
      chk({name, "_k2"}, 32'(kseq[2]), 32'(k2));
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_in_ready"}, 32'(IN_READY), 32'd0);
    chk({name, "_lut_en"}, 32'(LUT_EN), 32'd0);
    chk({name, "_out_valid"}, 32'(OUT_VALID), 32'd0);
    chk({name, "_busy"}, 32'(BUSY), 32'd0);
    chk({name, "_lut_din"}, LUT_DIN, 32'd0);
    chk({name, "_out_data"}, OUT_DATA, 32'd0);
    chk({name, "_key_idx"}, 32'(KEY_IDX), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    RST = 1'b1; GLOBAL_EN = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    IN_DATA = '0; MODE = 1'b0;
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    #1 chk("ready_after_reset", 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;

    // 1: ascending keys
    offer(32'hAAAAAAAA, 1'b0);
    wait_out("t1", 0, 0, 6, 32'hAAAAAAB0);
    chk_keys("t1", 2'd0, 2'd1, 2'd2);
    @(posedge CLK); #1;

    // 2: descending keys
    offer(32'hAAAAAAAA, 1'b1);
    wait_out("t2", 0, 0, 6, 32'hAAAAAAB0);
    chk_keys("t2", 2'd2, 2'd1, 2'd0);
    @(posedge CLK); #1;

    // 3: downstream back-pressure in DONE
    OUT_READY = 1'b0;
    offer(32'h00001000, 1'b0);
    wait_out("t3", 0, 0, 6, 32'h00001006);
    repeat (10) begin
      @(posedge CLK); #1;
      chk("t3_hold_data", OUT_DATA, 32'h00001006);
      chk("t3_hold_ready", 32'(IN_READY), 32'd0);
    end
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    chk("t3_ready_after", 32'(IN_READY), 32'd1);
    chk("t3_valid_after", 32'(OUT_VALID), 32'd0);

    // 4: five disabled cycles during the first WAIT
    offer(32'h12345678, 1'b0);
    wait_out("t4", 1, 5, 11, 32'h1234567E);
    chk_keys("t4", 2'd0, 2'd1, 2'd2);
    @(posedge CLK); #1;

    // 5: reset during the second round's WAIT
    offer(32'h11111111, 1'b0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    #1 chk_all_zero("t5_reset");
    @(posedge CLK); #1 RST = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (OUT_VALID) seen++;
    end
    chk("t5_no_out_valid", 32'(seen), 32'd0);
    offer(32'h00000000, 1'b0);
    wait_out("t5", 0, 0, 6, 32'h00000006);
    @(posedge CLK); #1;

    // 6: IN_VALID held high while busy
    OUT_READY = 1'b1;
    offer(32'h01000000, 1'b0);
    IN_VALID = 1'b1; IN_DATA = 32'h00000100; MODE = 1'b1;
    n = 0;
    seen = 0;
    while (n < 50) begin
      @(posedge CLK); #1; n++;
      if (OUT_VALID && seen == 0) begin
        seen = n;
        chk("t6_first_data", OUT_DATA, 32'h01000006);
      end
      if (IN_READY) break;
    end
    chk("t6_first_latency", 32'(seen), 32'd6);
    chk("t6_ready_cycle", 32'(n), 32'd7);
    kseq.delete();
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    wait_out("t6", 0, 0, 6, 32'h00000106);
    chk_keys("t6", 2'd2, 2'd1, 2'd0);
    repeat (3) @(posedge CLK);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
